// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals for alu_arbiter.
//
// Handshake: a requester raises reqN with selN/aN/bN/cN stable. The arbiter
// answers with gntN, which stays high until the end of the DONE cycle. In that
// DONE cycle doneN pulses for exactly one cycle and result/carry are valid.
// Operands are copied at the grant edge, so the requester may change or drop
// them afterwards. If reqN is still high after doneN, it counts as a new
// request.
interface alu_arbiter_if;
    logic       req0, req1;
    logic [2:0] sel0, sel1;
    logic [3:0] a0, b0, c0, a1, b1, c1;
    logic       gnt0, gnt1;
    logic       done0, done1;
    logic [3:0] result;
    logic       carry;
    logic       busy;
    logic [2:0] alu_select;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       alu_load;
    logic [3:0] alu_regout;
    logic       alu_carryout;

    // Driven by the requesters and the shared ALU.
    modport master (
        output req0, req1, sel0, sel1, a0, b0, c0, a1, b1, c1,
        output alu_regout, alu_carryout,
        input  gnt0, gnt1, done0, done1, result, carry, busy,
        input  alu_select, alu_a, alu_b, alu_c, alu_load
    );

    // Used by the arbiter itself.
    modport slave (
        input  req0, req1, sel0, sel1, a0, b0, c0, a1, b1, c1,
        input  alu_regout, alu_carryout,
        output gnt0, gnt1, done0, done1, result, carry, busy,
        output alu_select, alu_a, alu_b, alu_c, alu_load
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared, registered ALU.
// A grant latches the winner's operands. The ALU is then loaded for one
// cycle. After ALU_LAT edges the ALU output is captured, and the winner gets
// a one-cycle done pulse.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    alu_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT3 = 3'(ALU_LAT);

    state_t     state_q, state_d;
    logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic       last_q, last_d;      // 1: requester 1 won most recently
    logic [2:0] sel_q, sel_d;
    logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       pick1;

    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 0 was the last winner.
    assign pick1 = bus.req1 && (!bus.req0 || !last_q);

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            last_q   <= 1'b1;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count down in WAIT, capture on the
    // last WAIT edge.
    always_comb begin
        state_d  = state_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        last_d   = last_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    sel_d   = pick1 ? bus.sel1 : bus.sel0;
                    a_d     = pick1 ? bus.a1 : bus.a0;
                    b_d     = pick1 ? bus.b1 : bus.b0;
                    c_d     = pick1 ? bus.c1 : bus.c0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT3;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // The <= also guards against a zero count, which would
                // otherwise wrap and stall for eight edges.
                if (cnt_q <= 3'd1) begin
                    result_d = bus.alu_regout;
                    carry_d  = bus.alu_carryout;
                    last_d   = gnt1_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and the latched operands.
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = (state_q == DONE) && gnt0_q;
    assign bus.done1      = (state_q == DONE) && gnt1_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.alu_load   = (state_q == ISSUE);
    assign bus.alu_select = sel_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_c      = c_q;
    assign bus.result     = result_q;
    assign bus.carry      = carry_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter.
// Two instances are used: ALU_LAT=1 (u1) and ALU_LAT=4 (u4).
// The ALU output is modelled as the index of the current edge, so a captured
// value identifies the edge on which it was taken.
module tb_alu_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] dbg1, dbg4;

    alu_arbiter_if u1();
    alu_arbiter_if u4();

    alu_arbiter #(.ALU_LAT(1)) dut1 (.clock(clock), .reset(reset), .bus(u1.slave), .dbg_state_o(dbg1));
    alu_arbiter #(.ALU_LAT(4)) dut4 (.clock(clock), .reset(reset), .bus(u4.slave), .dbg_state_o(dbg4));

    // clock / reset block
    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    assign u1.alu_regout   = edge_n[3:0];
    assign u1.alu_carryout = ~edge_n[0];
    assign u4.alu_regout   = edge_n[3:0];
    assign u4.alu_carryout = ~edge_n[0];

    // one-hot monitor on gnt and done
    always @(negedge clock) begin
        if (reset) begin
            n_checks++; if ((u1.gnt0 & u1.gnt1) !== 1'b0) begin n_fail++; $display("FAIL u1_gnt_onehot got %b%b want not both", u1.gnt0, u1.gnt1); end
            n_checks++; if ((u1.done0 & u1.done1) !== 1'b0) begin n_fail++; $display("FAIL u1_done_onehot got %b%b want not both", u1.done0, u1.done1); end
            n_checks++; if ((u4.gnt0 & u4.gnt1) !== 1'b0) begin n_fail++; $display("FAIL u4_gnt_onehot got %b%b want not both", u4.gnt0, u4.gnt1); end
            n_checks++; if ((u4.done0 & u4.done1) !== 1'b0) begin n_fail++; $display("FAIL u4_done_onehot got %b%b want not both", u4.done0, u4.done1); end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_idle();
        u1.req0 = 0; u1.req1 = 0; u1.sel0 = 0; u1.sel1 = 0;
        u1.a0 = 0; u1.b0 = 0; u1.c0 = 0; u1.a1 = 0; u1.b1 = 0; u1.c1 = 0;
        u4.req0 = 0; u4.req1 = 0; u4.sel0 = 0; u4.sel1 = 0;
        u4.a0 = 0; u4.b0 = 0; u4.c0 = 0; u4.a1 = 0; u4.b1 = 0; u4.c1 = 0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (u1.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0 got %b want 0", u1.gnt0); end
        n_checks++; if (u1.gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1 got %b want 0", u1.gnt1); end
        n_checks++; if (u1.done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done0 got %b want 0", u1.done0); end
        n_checks++; if (u1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", u1.busy); end
        n_checks++; if (u1.alu_load !== 1'b0) begin n_fail++; $display("FAIL rst_load got %b want 0", u1.alu_load); end
        n_checks++; if (u1.result !== 4'h0) begin n_fail++; $display("FAIL rst_result got %h want 0", u1.result); end
        n_checks++; if (u1.carry !== 1'b0) begin n_fail++; $display("FAIL rst_carry got %b want 0", u1.carry); end
        n_checks++; if (u1.alu_select !== 3'd0) begin n_fail++; $display("FAIL rst_sel got %h want 0", u1.alu_select); end
        n_checks++; if (u1.alu_a !== 4'h0) begin n_fail++; $display("FAIL rst_a got %h want 0", u1.alu_a); end
        n_checks++; if (dbg1 !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", dbg1); end
        n_checks++; if (u4.busy !== 1'b0) begin n_fail++; $display("FAIL rst_u4_busy got %b want 0", u4.busy); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int g;
        logic [3:0] er;
        @(negedge clock);
        u1.req0 = 1; u1.sel0 = 3; u1.a0 = 5; u1.b0 = 2; u1.c0 = 0;
        g = edge_n;
        er = 4'(g + 2);
        @(negedge clock); // ISSUE
        n_checks++; if (u1.gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0 got %b want 1", u1.gnt0); end
        n_checks++; if (u1.gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1 got %b want 0", u1.gnt1); end
        n_checks++; if (u1.alu_load !== 1'b1) begin n_fail++; $display("FAIL single_load got %b want 1", u1.alu_load); end
        n_checks++; if (u1.alu_select !== 3'd3) begin n_fail++; $display("FAIL single_sel got %0d want 3", u1.alu_select); end
        n_checks++; if (u1.alu_a !== 4'd5) begin n_fail++; $display("FAIL single_a got %0d want 5", u1.alu_a); end
        n_checks++; if (u1.alu_b !== 4'd2) begin n_fail++; $display("FAIL single_b got %0d want 2", u1.alu_b); end
        n_checks++; if (u1.alu_c !== 4'd0) begin n_fail++; $display("FAIL single_c got %0d want 0", u1.alu_c); end
        n_checks++; if (dbg1 !== 2'd1) begin n_fail++; $display("FAIL single_state got %0d want 1", dbg1); end
        u1.req0 = 0;
        @(negedge clock); // WAIT
        n_checks++; if (u1.alu_load !== 1'b0) begin n_fail++; $display("FAIL single_load_wait got %b want 0", u1.alu_load); end
        n_checks++; if (u1.done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_early got %b want 0", u1.done0); end
        n_checks++; if (u1.result !== 4'h0) begin n_fail++; $display("FAIL single_result_early got %h want 0", u1.result); end
        @(negedge clock); // DONE
        n_checks++; if (u1.done0 !== 1'b1) begin n_fail++; $display("FAIL single_done0 got %b want 1", u1.done0); end
        n_checks++; if (u1.done1 !== 1'b0) begin n_fail++; $display("FAIL single_done1 got %b want 0", u1.done1); end
        n_checks++; if (u1.result !== er) begin n_fail++; $display("FAIL single_result got %h want %h", u1.result, er); end
        n_checks++; if (u1.carry !== ~er[0]) begin n_fail++; $display("FAIL single_carry got %b want %b", u1.carry, ~er[0]); end
        n_checks++; if (u1.gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt_done got %b want 1", u1.gnt0); end
        @(negedge clock); // IDLE
        n_checks++; if (u1.done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_after got %b want 0", u1.done0); end
        n_checks++; if (u1.gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt_after got %b want 0", u1.gnt0); end
        n_checks++; if (u1.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", u1.busy); end
        n_checks++; if (u1.result !== er) begin n_fail++; $display("FAIL single_result_hold got %h want %h", u1.result, er); end
        n_checks++; if (u1.alu_a !== 4'd5) begin n_fail++; $display("FAIL single_a_hold got %0d want 5", u1.alu_a); end
    endtask

    task automatic test_round_robin();
        int own;
        @(negedge clock);
        reset = 1'b0;
        u1.req0 = 1; u1.sel0 = 1; u1.a0 = 1;
        u1.req1 = 1; u1.sel1 = 2; u1.a1 = 2;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            own = k % 2;
            for (int off = 0; off < 4; off++) begin
                @(negedge clock);
                if (off == 0) begin
                    n_checks++; if (u1.gnt0 !== (own == 0)) begin n_fail++; $display("FAIL rr_gnt0 op%0d got %b want %b", k, u1.gnt0, own == 0); end
                    n_checks++; if (u1.gnt1 !== (own == 1)) begin n_fail++; $display("FAIL rr_gnt1 op%0d got %b want %b", k, u1.gnt1, own == 1); end
                    n_checks++; if (u1.alu_a !== ((own == 1) ? 4'd2 : 4'd1)) begin n_fail++; $display("FAIL rr_a op%0d got %0d want %0d", k, u1.alu_a, own + 1); end
                end
                if (off == 2) begin
                    n_checks++; if (u1.done0 !== (own == 0)) begin n_fail++; $display("FAIL rr_done0 op%0d got %b want %b", k, u1.done0, own == 0); end
                    n_checks++; if (u1.done1 !== (own == 1)) begin n_fail++; $display("FAIL rr_done1 op%0d got %b want %b", k, u1.done1, own == 1); end
                end
                if (off == 3) begin
                    n_checks++; if (u1.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle op%0d got %b want 0", k, u1.busy); end
                    if (k == 3) begin u1.req0 = 0; u1.req1 = 0; end
                end
            end
        end
    endtask

    task automatic test_drop();
        @(negedge clock);
        u1.req0 = 1; u1.sel0 = 6; u1.a0 = 9; u1.b0 = 1; u1.c0 = 4;
        @(negedge clock); // ISSUE
        n_checks++; if (u1.alu_select !== 3'd6) begin n_fail++; $display("FAIL drop_sel_issue got %0d want 6", u1.alu_select); end
        u1.req0 = 0; u1.sel0 = 2; u1.a0 = 3; u1.b0 = 7; u1.c0 = 8;
        @(negedge clock); // WAIT
        n_checks++; if (u1.alu_select !== 3'd6) begin n_fail++; $display("FAIL drop_sel got %0d want 6", u1.alu_select); end
        n_checks++; if (u1.alu_a !== 4'd9) begin n_fail++; $display("FAIL drop_a got %0d want 9", u1.alu_a); end
        n_checks++; if (u1.alu_b !== 4'd1) begin n_fail++; $display("FAIL drop_b got %0d want 1", u1.alu_b); end
        n_checks++; if (u1.alu_c !== 4'd4) begin n_fail++; $display("FAIL drop_c got %0d want 4", u1.alu_c); end
        @(negedge clock); // DONE
        n_checks++; if (u1.done0 !== 1'b1) begin n_fail++; $display("FAIL drop_done0 got %b want 1", u1.done0); end
        @(negedge clock); // IDLE, no new request
        n_checks++; if (u1.alu_a !== 4'd9) begin n_fail++; $display("FAIL drop_a_hold got %0d want 9", u1.alu_a); end
        @(negedge clock);
        n_checks++; if (u1.busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_regrant got %b want 0", u1.busy); end
    endtask

    task automatic test_latency4();
        int g;
        logic [3:0] er;
        @(negedge clock);
        u4.req1 = 1; u4.sel1 = 5; u4.a1 = 7; u4.b1 = 8; u4.c1 = 9;
        g = edge_n;
        er = 4'(g + 5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            n_checks++; if (u4.busy !== (i <= 5)) begin n_fail++; $display("FAIL lat4_busy off%0d got %b want %b", i, u4.busy, i <= 5); end
            n_checks++; if (u4.done1 !== (i == 5)) begin n_fail++; $display("FAIL lat4_done1 off%0d got %b want %b", i, u4.done1, i == 5); end
            n_checks++; if (u4.alu_load !== (i == 0)) begin n_fail++; $display("FAIL lat4_load off%0d got %b want %b", i, u4.alu_load, i == 0); end
            n_checks++; if (u4.gnt1 !== (i <= 5)) begin n_fail++; $display("FAIL lat4_gnt1 off%0d got %b want %b", i, u4.gnt1, i <= 5); end
            if (i == 0) begin
                n_checks++; if (u4.alu_a !== 4'd7) begin n_fail++; $display("FAIL lat4_a got %0d want 7", u4.alu_a); end
                u4.req1 = 0;
            end
            if (i == 4) begin
                n_checks++; if (u4.result !== 4'h0) begin n_fail++; $display("FAIL lat4_result_early got %h want 0", u4.result); end
            end
            if (i == 5) begin
                n_checks++; if (u4.result !== er) begin n_fail++; $display("FAIL lat4_result got %h want %h", u4.result, er); end
                n_checks++; if (u4.carry !== ~er[0]) begin n_fail++; $display("FAIL lat4_carry got %b want %b", u4.carry, ~er[0]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        u4.req0 = 1; u4.a0 = 3; u4.sel0 = 2;
        @(negedge clock); // ISSUE
        u4.req0 = 0;
        @(negedge clock); // WAIT
        @(negedge clock); // WAIT
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (u4.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt0 got %b want 0", u4.gnt0); end
        n_checks++; if (u4.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", u4.busy); end
        n_checks++; if (u4.alu_a !== 4'h0) begin n_fail++; $display("FAIL rmid_a got %h want 0", u4.alu_a); end
        n_checks++; if (u4.alu_select !== 3'd0) begin n_fail++; $display("FAIL rmid_sel got %0d want 0", u4.alu_select); end
        n_checks++; if (u4.result !== 4'h0) begin n_fail++; $display("FAIL rmid_result got %h want 0", u4.result); end
        n_checks++; if (u1.result !== 4'h0) begin n_fail++; $display("FAIL rmid_u1_result got %h want 0", u1.result); end
        n_checks++; if (dbg4 !== 2'd0) begin n_fail++; $display("FAIL rmid_state got %0d want 0", dbg4); end
        @(negedge clock);
        n_checks++; if (u4.done0 !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", u4.done0); end
        u4.req0 = 1; u4.req1 = 1; u4.a0 = 4'hB; u4.a1 = 4'hD;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (u4.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rmid_tie_gnt0 got %b want 1", u4.gnt0); end
        n_checks++; if (u4.gnt1 !== 1'b0) begin n_fail++; $display("FAIL rmid_tie_gnt1 got %b want 0", u4.gnt1); end
        n_checks++; if (u4.alu_a !== 4'hB) begin n_fail++; $display("FAIL rmid_tie_a got %h want b", u4.alu_a); end
        u4.req0 = 0; u4.req1 = 0;
        repeat (8) @(negedge clock);
        n_checks++; if (u4.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_settle got %b want 0", u4.busy); end
    endtask

    task automatic test_back_to_back();
        int m;
        @(negedge clock);
        u1.req0 = 1; u1.a0 = 4'hC; u1.sel0 = 7;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            m = i % 4;
            n_checks++; if (u1.gnt0 !== (m != 3)) begin n_fail++; $display("FAIL b2b_gnt0 cyc%0d got %b want %b", i, u1.gnt0, m != 3); end
            n_checks++; if (u1.done0 !== (m == 2)) begin n_fail++; $display("FAIL b2b_done0 cyc%0d got %b want %b", i, u1.done0, m == 2); end
            n_checks++; if (u1.alu_load !== (m == 0)) begin n_fail++; $display("FAIL b2b_load cyc%0d got %b want %b", i, u1.alu_load, m == 0); end
            n_checks++; if (u1.gnt1 !== 1'b0) begin n_fail++; $display("FAIL b2b_gnt1 cyc%0d got %b want 0", i, u1.gnt1); end
            if (i == 11) u1.req0 = 0;
        end
        @(negedge clock);
        n_checks++; if (u1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %b want 0", u1.busy); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_latency4();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
